// File: rtl/pll_rst_pkg.sv
// Shared types and defaults for the PLL reset sequencer.
// Optional loss counter is enabled with the PLL_LOSS_COUNT_EN macro in the top.
package pll_rst_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        STAGE     = 2'd2,
        RUN       = 2'd3
    } pll_rst_state_t;

    localparam int PLL_LOCK_CYCLES_DEF = 1024;
    localparam int PLL_STAGE_GAP_DEF   = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer with async active-low clear.
// Latency: 2 clk edges; no backpressure.
// Output is 0 while rst_n is low.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Staged core/peripheral reset release after PLL lock; loss of lock re-asserts both resets.
// Latency: core release LOCK_CYCLES+2 edges after lock, periph STAGE_GAP later; loss at 3rd edge.
// No backpressure. Optional saturating loss counter with PLL_LOSS_COUNT_EN.
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int LOCK_CYCLES = PLL_LOCK_CYCLES_DEF,
    parameter int STAGE_GAP   = PLL_STAGE_GAP_DEF,
    parameter int LOSS_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              locked,
    input  logic              clr_lost,
    output logic              core_rst_n,
    output logic              periph_rst_n,
    output logic              ready,
    output logic              lock_lost
`ifdef PLL_LOSS_COUNT_EN
    ,
    output logic [LOSS_W-1:0] loss_count
`endif
);

    localparam int CNT_W = $clog2(max_int(LOCK_CYCLES, STAGE_GAP)) + 1;

    // Entering STABLE already accounts for one locked cycle, hence the -2.
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 2);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_GAP - 1);

    pll_rst_state_t   state;
    logic [CNT_W-1:0] cnt;
    logic             locked_s;
    logic             loss_evt;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (locked),
        .q     (locked_s)
    );

    assign loss_evt = !locked_s && ((state == STAGE) || (state == RUN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WAIT_LOCK;
            cnt          <= '0;
            core_rst_n   <= 1'b0;
            periph_rst_n <= 1'b0;
            ready        <= 1'b0;
            lock_lost    <= 1'b0;
        end else begin
            // Set is written after clear so a coincident loss event wins.
            if (clr_lost) begin
                lock_lost <= 1'b0;
            end
            if (loss_evt) begin
                lock_lost <= 1'b1;
            end

            case (state)
                WAIT_LOCK: begin
                    cnt <= '0;
                    if (locked_s) begin
                        state <= STABLE;
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == LOCK_LAST) begin
                        state      <= STAGE;
                        cnt        <= '0;
                        core_rst_n <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STAGE, RUN: begin
                    if (loss_evt) begin
                        state        <= WAIT_LOCK;
                        cnt          <= '0;
                        core_rst_n   <= 1'b0;
                        periph_rst_n <= 1'b0;
                        ready        <= 1'b0;
                    end else if (state == STAGE) begin
                        if (cnt == STAGE_LAST) begin
                            state        <= RUN;
                            cnt          <= '0;
                            periph_rst_n <= 1'b1;
                            ready        <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= WAIT_LOCK;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef PLL_LOSS_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_count <= '0;
        end else if (loss_evt && (loss_count != {LOSS_W{1'b1}})) begin
            loss_count <= loss_count + 1'b1;
        end
    end
`endif

endmodule
